// File: rtl/top_level.sv
// Pattern-search engine: reads a 5-bit pattern and a 32-byte message from the
// internal data memory dm1, counts matches three ways (in-byte windows, bytes with
// any in-byte hit, and all 252 stream windows), then writes the counts to
// core[33..35] and raises done.
//
// Build option: define TOP_LEVEL_DONE_PULSE_EN to make done a single-cycle pulse on
// entry to the final state. Otherwise done stays high until the next reset.

// 256 x 8 data memory: combinational read, synchronous write, no reset so that
// preloaded contents and earlier results survive a reset pulse.
module top_level_dm (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] core [0:255];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end

  // Combinational read port
  always_comb begin
    rdata = core[raddr];
  end

endmodule

module top_level (
  input  logic clk,
  input  logic reset,
  output logic done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLdPat = 3'd1;
  localparam logic [2:0] StScan  = 3'd2;
  localparam logic [2:0] StWr33  = 3'd3;
  localparam logic [2:0] StWr34  = 3'd4;
  localparam logic [2:0] StWr35  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam logic [7:0] PatAddr = 8'd32;
  localparam logic [7:0] CtbAddr = 8'd33;
  localparam logic [7:0] CtoAddr = 8'd34;
  localparam logic [7:0] CtsAddr = 8'd35;

  logic [2:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] prev_q, prev_d;
  logic [4:0] pat_q, pat_d;
  logic [7:0] ctb_q, ctb_d;
  logic [7:0] cto_q, cto_d;
  logic [7:0] ctx_q, ctx_d;
  logic       done_q, done_d;

  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;

  logic [3:0] in_hit;
  logic [3:0] cross_hit;
  logic [2:0] in_cnt;
  logic [2:0] cross_cnt;
  logic [7:0] cts;

  top_level_dm dm1 (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Number of set bits in a 4-bit hit vector
  function automatic logic [2:0] count4(input logic [3:0] v);
    count4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Read port: pattern byte while loading, otherwise the byte under scan
  always_comb begin
    mem_raddr = (state_q == StLdPat) ? PatAddr : {3'b000, idx_q};
  end

  // Window comparators for the current byte and the prev/cur byte boundary
  always_comb begin
    in_hit[0]    = (mem_rdata[4:0] == pat_q);
    in_hit[1]    = (mem_rdata[5:1] == pat_q);
    in_hit[2]    = (mem_rdata[6:2] == pat_q);
    in_hit[3]    = (mem_rdata[7:3] == pat_q);
    cross_hit[0] = ({prev_q[3:0], mem_rdata[7]}   == pat_q);
    cross_hit[1] = ({prev_q[2:0], mem_rdata[7:6]} == pat_q);
    cross_hit[2] = ({prev_q[1:0], mem_rdata[7:5]} == pat_q);
    cross_hit[3] = ({prev_q[0],   mem_rdata[7:4]} == pat_q);
    in_cnt       = count4(in_hit);
    cross_cnt    = count4(cross_hit);
  end

  // Stream count: in-byte matches plus boundary-crossing matches (max 252, fits 8 bits)
  always_comb begin
    cts = ctb_q + ctx_q;
  end

  // Result write port, active only in the three write states
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = CtbAddr;
    mem_wdata = ctb_q;
    case (state_q)
      StWr33: begin
        mem_we    = 1'b1;
        mem_waddr = CtbAddr;
        mem_wdata = ctb_q;
      end
      StWr34: begin
        mem_we    = 1'b1;
        mem_waddr = CtoAddr;
        mem_wdata = cto_q;
      end
      StWr35: begin
        mem_we    = 1'b1;
        mem_waddr = CtsAddr;
        mem_wdata = cts;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    pat_d   = pat_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    ctx_d   = ctx_q;
    case (state_q)
      StIdle: begin
        state_d = StLdPat;
      end
      StLdPat: begin
        pat_d   = mem_rdata[7:3];
        idx_d   = 5'd0;
        state_d = StScan;
      end
      StScan: begin
        ctb_d  = ctb_q + {5'b00000, in_cnt};
        cto_d  = cto_q + {7'b0000000, |in_hit};
        // Byte 0 has no predecessor, so no crossing windows yet
        if (idx_q != 5'd0) begin
          ctx_d = ctx_q + {5'b00000, cross_cnt};
        end
        prev_d = mem_rdata;
        idx_d  = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = StWr33;
        end
      end
      StWr33: begin
        state_d = StWr34;
      end
      StWr34: begin
        state_d = StWr35;
      end
      StWr35: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // done is registered so it rises on the same edge that enters the final state
  always_comb begin
`ifdef TOP_LEVEL_DONE_PULSE_EN
    done_d = (state_q == StWr35);
`else
    done_d = (state_q == StWr35) || done_q;
`endif
  end

  // State registers; reset aborts any run but leaves memory untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 5'd0;
      prev_q  <= 8'd0;
      pat_q   <= 5'd0;
      ctb_q   <= 8'd0;
      cto_q   <= 8'd0;
      ctx_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
      pat_q   <= pat_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      ctx_q   <= ctx_d;
      done_q  <= done_d;
    end
  end

  // Output drive
  always_comb begin
    done = done_q;
  end

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: preloads dm1, runs the engine and checks the three
// counts, the done timing, done behaviour after completion, and that no other
// memory location is disturbed.
module tb_top_level;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  logic [7:0] model [0:255];

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Build the expected memory image: message fill, pattern byte, sentinels above
  task automatic load(input logic [7:0] fill, input logic [7:0] patbyte);
    for (int i = 0; i < 32; i++) model[i] = fill;
    model[32] = patbyte;
    for (int i = 33; i < 36; i++) model[i] = 8'hEE;
    for (int i = 36; i < 256; i++) model[i] = 8'(i * 7 + 3);
  endtask

  task automatic push();
    for (int i = 0; i < 256; i++) dut.dm1.core[i] = model[i];
  endtask

  // Hold reset across one edge, preload while idle, then release
  task automatic start_run(input string tag);
    @(negedge clk);
    reset = 1'b1;
    push();
    @(negedge clk);
    check({tag, "_reset_done"}, {31'd0, done}, 32'd0);
    reset = 1'b0;
  endtask

  // Count edges after reset release until done; 0 means timeout
  task automatic wait_done(output int c);
    c = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        c = n;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input logic [7:0] ctb, input logic [7:0] cto,
                               input logic [7:0] cts);
    int bad;
    check({tag, "_ctb"}, {24'd0, dut.dm1.core[33]}, {24'd0, ctb});
    check({tag, "_cto"}, {24'd0, dut.dm1.core[34]}, {24'd0, cto});
    check({tag, "_cts"}, {24'd0, dut.dm1.core[35]}, {24'd0, cts});
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if ((i < 33 || i > 35) && dut.dm1.core[i] !== model[i]) bad++;
    end
    check({tag, "_untouched"}, bad, 0);
    @(posedge clk);
    #1;
`ifdef TOP_LEVEL_DONE_PULSE_EN
    check({tag, "_done_after"}, {31'd0, done}, 32'd0);
`else
    check({tag, "_done_after"}, {31'd0, done}, 32'd1);
`endif
  endtask

  initial begin
    // P=10101 over 0xAA: two in-byte hits per byte, stream hits at every even offset
    load(8'hAA, 8'hA8);
    start_run("alt");
    wait_done(cyc);
    check("alt_done_cycle", cyc, 37);
    check_results("alt", 8'd64, 8'd32, 8'd126);

    // P=11111 over all ones: every window matches
    load(8'hFF, 8'hF8);
    start_run("ones");
    wait_done(cyc);
    check("ones_done_cycle", cyc, 37);
    check_results("ones", 8'd128, 8'd32, 8'd252);

    // P=00000 over all ones: nothing matches
    load(8'hFF, 8'h00);
    start_run("zero");
    wait_done(cyc);
    check("zero_done_cycle", cyc, 37);
    check_results("zero", 8'd0, 8'd0, 8'd0);

    // Single match straddling bytes 0 and 1
    load(8'h00, 8'hF8);
    model[0] = 8'h03;
    model[1] = 8'hE0;
    start_run("cross");
    wait_done(cyc);
    check("cross_done_cycle", cyc, 37);
    check_results("cross", 8'd0, 8'd0, 8'd1);

    // Match in the last byte only; pattern byte low bits set must be ignored
    load(8'h00, 8'hFF);
    model[31] = 8'h1F;
    start_run("last");
    wait_done(cyc);
    check("last_done_cycle", cyc, 37);
    check_results("last", 8'd1, 8'd1, 8'd1);

    // Reset pulse mid-run, then full rerun
    load(8'hAA, 8'hA8);
    start_run("abort");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("abort_done_before", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_done_in_reset", {31'd0, done}, 32'd0);
    reset = 1'b0;
    check("abort_ctb_unwritten", {24'd0, dut.dm1.core[33]}, 32'hEE);
    check("abort_cto_unwritten", {24'd0, dut.dm1.core[34]}, 32'hEE);
    check("abort_cts_unwritten", {24'd0, dut.dm1.core[35]}, 32'hEE);
    wait_done(cyc);
    check("abort_done_cycle", cyc, 37);
    check_results("abort", 8'd64, 8'd32, 8'd126);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top_level.md
# top_level

Self-contained pattern-search engine, used as the top of the program-3 datapath. A one-cycle reset pulse starts a run. The engine reads a 5-bit pattern and a 32-byte message from its internal data memory `dm1`, counts pattern occurrences three ways, writes the three counts back to memory, then raises `done`.

## Interface
- Parameters: none.
- `clk`  input  1  single system clock, rising edge.
- `reset`  input  1  asynchronous, active-high; a pulse requests a new run.
- `done`  output  1  high when results are valid in memory.
- Required internal instance `dm1`, containing array `core`: 256 × 8 bits, addressable hierarchically as `dm1.core[i]`.
  - Benches preload it directly and read results directly.
  - Read is combinational; write is synchronous on `clk`.

## Operation
- Memory map:
  - `core[0..31]` holds the message. `core[0]` is the most significant byte of the 256-bit stream; bit 7 of each byte is its MSB.
  - `core[32][7:3]` holds the pattern P; bits 2:0 are ignored.
  - Outputs: `core[33]` = CTB, `core[34]` = CTO, `core[35]` = CTS.
- Reset never modifies `core`.
- CTB: number of matches of P against the in-byte windows `[4:0]`, `[5:1]`, `[6:2]` and `[7:3]`, summed over all 32 bytes. Maximum is 128.
- CTO: number of bytes with at least one in-byte window match. Maximum is 32.
- CTS: number of matches over all 252 five-bit windows of the 256-bit stream, including windows that cross byte boundaries. Maximum is 252.
- CTS is computed as CTB plus the crossing windows, with prev = byte i−1 and cur = byte i, for i = 1..31. The four crossing windows are:
  - `{prev[3:0], cur[7]}`
  - `{prev[2:0], cur[7:6]}`
  - `{prev[1:0], cur[7:5]}`
  - `{prev[0], cur[7:4]}`
- All counters are 8-bit. They cannot overflow, so no saturation is needed.
- FSM states: IDLE, LDPAT, SCAN, WR33, WR34, WR35, DONE.
  - Reset forces IDLE and clears the counters, byte index, prev-byte register and `done`.
  - IDLE → LDPAT on the first edge after reset deasserts.
  - LDPAT: latch `core[32][7:3]` into the P register.
  - SCAN: byte index 0..31, one byte per cycle.
    - Add the in-byte window matches (0–4) to CTB.
    - Add 1 to CTO if any window matched.
    - For index ≥ 1, add the crossing-window matches to the crossing count.
    - Store cur into the prev-byte register.
    - After index 31, go to WR33.
  - WR33 writes CTB, WR34 writes CTO, WR35 writes CTB + crossing count, one write per cycle.
  - DONE: `done` = 1. The FSM stays in DONE until the next reset.
- No memory writes occur outside WR33–WR35.

## Timing
- Reset values: `done` = 0, state = IDLE.
- Cycle 1 is the first rising edge with `reset` low; it moves IDLE → LDPAT.
- Cycles 2–33 are SCAN. Cycles 34–36 write `core[33]`, `core[34]` and `core[35]`.
- `done` rises at cycle 37, which is 37 rising edges after reset falls.
- Reset asserted mid-run:
  - aborts the run immediately and drops `done`;
  - leaves any already-written results unchanged;
  - starts a full rerun after deassertion, rereading the pattern and message.
- Memory preloaded while the FSM is in IDLE is fully honoured.
- Memory changed during SCAN gives undefined results.

## Configuration
- `TOP_LEVEL_DONE_PULSE_EN` defined: `done` is a one-cycle pulse on entry to DONE, then returns to 0 while the FSM stays in DONE.
- Macro undefined (default): `done` stays high in DONE until reset.

## Test plan
- P = 10101, all bytes 0xAA → CTB = 64, CTO = 32, CTS = 126; `done` at cycle 37.
- P = 11111, all bytes 0xFF → CTB = 128, CTO = 32, CTS = 252. Also P = 00000 with all bytes 0xFF → 0, 0, 0.
- P = 11111, `core[0]` = 0x03, `core[1]` = 0xE0, others 0x00 → CTB = 0, CTO = 0, CTS = 1 (crossing-window match only).
- P = 11111, `core[31]` = 0x1F, others 0 → CTB = 1, CTO = 1, CTS = 1; `core[32][2:0]` = 111 must not change the results.
- Reset pulse at cycle 20 of a run with P = 10101 and all bytes 0xAA:
  - `done` stays 0 and `core[33..35]` are unwritten until the rerun completes;
  - the rerun ends 37 cycles after the second reset falls with 64 / 32 / 126.
- Message bytes and `core[36..255]` are unchanged after a run; under `TOP_LEVEL_DONE_PULSE_EN`, `done` is high for exactly one cycle.
